screen_flow_controller: RTL and testbench
=========================================

Name: screen_flow_controller

Overview:
Top-level game sequencer that sits directly downstream of the main play screen. It consumes the main screen's life/score counters and RGB stream and walks the game through start, play, game-over and win screens. It generates the one-cycle start pulse and a game-restart pulse that feed back into the main screen, and it registers the final pixel colour for the VGA driver. It also keeps a session high score that survives across games and is cleared only by reset.

Parameters:
GRACE_FRAMES, 8, frames after the start pulse during which life/score are ignored, so stale counters cannot end the game.
HOLD_FRAMES, 120, minimum frames an end screen is shown before key5 is accepted.
WIN_SCORE, 9, score at or above which the game is won.

Ports:
clk  in  1  system clock (pixel clock domain).
resetN  in  1  reset; synchronous, active-high: asserted when 1.
startOfFrame  in  1  one-cycle pulse per video frame.
key5IsPressed  in  1  level from keypad; start/continue button.
life  in  4  remaining lives from the main screen.
score  in  4  current score from the main screen.
RGB_screen_main  in  8  pixel from the main screen.
RGB_screen_start  in  8  pixel from the start-screen renderer.
RGB_screen_end  in  8  pixel from the end-screen renderer (shared by game-over and win).
start  out  1  one-cycle pulse into the main screen's start input.
game_restart  out  1  one-cycle pulse; clears the main screen's game state.
RGB_out  out  8  registered final pixel.
screen_state  out  2  current state encoding, used by the end-screen renderer.
win  out  1  high while in WIN.
high_score  out  4  best score this session.

Behaviour:
- Reset (resetN==1 at a clk edge): state=S_START, frame_cnt=0, key_prev=1, start=0, game_restart=0, RGB_out=0, high_score=0, win=0. A reset mid-game aborts immediately; no pulses are emitted.
- key_prev initialises to 1 so that a key held through reset does not register as a press.
- key_rise = key5IsPressed & ~key_prev. key_prev is registered every cycle.
- frame_cnt (8-bit) clears on every state entry. It increments on startOfFrame and saturates at 255.
- State encoding: S_START=0, S_PLAY=1, S_OVER=2, S_WIN=3. All outputs below are registered.
- S_START: on key_rise -> S_PLAY, with start=1 for exactly that transition cycle.
- S_PLAY: evaluated only when frame_cnt >= GRACE_FRAMES.
  - life==0 -> S_OVER.
  - else score >= WIN_SCORE -> S_WIN.
  - If both conditions hold in the same cycle, S_OVER has priority.
- Entering S_OVER or S_WIN: if score > high_score, high_score <= score in the same cycle. The comparison is unsigned 4-bit.
- S_OVER / S_WIN: key_rise is ignored while frame_cnt < HOLD_FRAMES.
  - A key held across the hold expiry must be released and pressed again.
  - First key_rise with frame_cnt >= HOLD_FRAMES -> S_START, with game_restart=1 for exactly that transition cycle.
- start and game_restart are never high in the same cycle. Each is high for exactly one cycle per transition.
- win = (state==S_WIN).
- RGB_out is one-cycle latency from the RGB inputs. It selects by the current (pre-transition) state:
  - S_START -> RGB_screen_start.
  - S_PLAY -> RGB_screen_main.
  - S_OVER / S_WIN -> RGB_screen_end.
- startOfFrame coinciding with a transition: the counter clears; the increment is lost.
- key_rise coinciding with a PLAY end condition: the key is ignored.
- HOLD_FRAMES > 255 is illegal; the block carries a synthesis-time assertion for it.

Decomposition:
- Shared package game_pkg holds:
  - typedef enum logic [1:0] screen_state_t {S_START, S_PLAY, S_OVER, S_WIN};
  - constants GRACE_FRAMES_DEF, HOLD_FRAMES_DEF, WIN_SCORE_DEF.
  - The end-screen renderer imports the enum.
- One sub-module, key_edge_detect (register plus rising-edge output, reset value 1), reused for key4/key6 elsewhere.
- The FSM, frame counter, high score and RGB mux stay in this module.

Test Plan:
1. Reset, then key5 0->1 -> start high exactly 1 cycle, screen_state=1. RGB_out equals RGB_screen_main one cycle later (drive 8'hA5 -> 8'hA5).
2. In PLAY, drive life=0 during frames 0..7 -> stays S_PLAY. At frame 8 -> S_OVER within 1 cycle, no start/game_restart pulse.
3. life=0 and score=9 on the same cycle after grace -> S_OVER (not WIN); high_score=9.
4. In S_OVER, press key5 at frame 50 and hold -> no transition. Release, press at frame 130 -> S_START, game_restart=1 for 1 cycle.
5. Game 1 ends with score 5, game 2 with score 3 -> high_score stays 5. Reach score 9 -> S_WIN, win=1, high_score=9.
6. Assert resetN mid-PLAY for 1 cycle with key5 held -> S_START, all outputs 0. Holding key5 does not restart; release and re-press is required.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared screen-state encoding and default game tuning constants
package game_pkg;
  typedef enum logic [1:0] {S_START, S_PLAY, S_OVER, S_WIN} screen_state_t;
  localparam int GRACE_FRAMES_DEF = 8;
  localparam int HOLD_FRAMES_DEF = 120;
  localparam int WIN_SCORE_DEF = 9;
endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: registers a key level and flags its rising edge; reset assumes the key was held
module key_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic rise
);
  logic keyPrev;
  // previous key level, forced high in reset so a held key is not seen as a press
  always_ff @(posedge clk) keyPrev <= rst ? 1'b1 : key;
  assign rise = key & ~keyPrev;
endmodule

// File: rtl/screen_flow_controller.sv
// screen_flow_controller: start/play/over/win sequencer with pulses, high score and final pixel mux
module screen_flow_controller
  import game_pkg::*;
#(
  parameter int GRACE_FRAMES = GRACE_FRAMES_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
  parameter int WIN_SCORE = WIN_SCORE_DEF
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       key5IsPressed,
  input  logic [3:0] life,
  input  logic [3:0] score,
  input  logic [7:0] RGB_screen_main,
  input  logic [7:0] RGB_screen_start,
  input  logic [7:0] RGB_screen_end,
  output logic       start,
  output logic       game_restart,
  output logic [7:0] RGB_out,
  output logic [1:0] screen_state,
  output logic       win,
  output logic [3:0] high_score
);
  localparam logic [7:0] graceFrames = 8'(GRACE_FRAMES);
  localparam logic [7:0] holdFrames = 8'(HOLD_FRAMES);
  localparam logic [3:0] winScore = 4'(WIN_SCORE);
  if (HOLD_FRAMES > 255) begin : gHoldCheck
    $error("HOLD_FRAMES must not exceed 255");
  end
  screen_state_t state, nextState;
  logic [7:0] frameCnt;
  logic keyRise, playEnd, endDone;
  key_edge_detect uKey5 (
    .clk (clk),
    .rst (resetN),
    .key (key5IsPressed),
    .rise(keyRise)
  );
  // next screen: game-over beats win, end screens need the hold time plus a fresh press
  always_comb begin
    playEnd = state == S_PLAY && frameCnt >= graceFrames;
    endDone = (state == S_OVER || state == S_WIN) && keyRise && frameCnt >= holdFrames;
    nextState = (state == S_START && keyRise) ? S_PLAY :
                (playEnd && life == 4'd0) ? S_OVER :
                (playEnd && score >= winScore) ? S_WIN :
                endDone ? S_START : state;
  end
  // state, per-state frame counter, one-cycle pulses, win flag and session high score
  always_ff @(posedge clk) begin
    if (resetN) begin
      state <= S_START;
      frameCnt <= 8'd0;
      start <= 1'b0;
      game_restart <= 1'b0;
      win <= 1'b0;
      high_score <= 4'd0;
    end else begin
      state <= nextState;
      frameCnt <= (nextState != state) ? 8'd0 :
                  (startOfFrame && frameCnt != 8'hFF) ? frameCnt + 8'd1 : frameCnt;
      start <= state == S_START && nextState == S_PLAY;
      game_restart <= state != S_START && nextState == S_START;
      win <= nextState == S_WIN;
      high_score <= (state == S_PLAY && nextState != S_PLAY && score > high_score) ? score : high_score;
    end
  end
  // final pixel chosen by the screen currently shown, one cycle of latency
  always_ff @(posedge clk) begin
    if (resetN) RGB_out <= 8'd0;
    else RGB_out <= (state == S_START) ? RGB_screen_start :
                    (state == S_PLAY) ? RGB_screen_main : RGB_screen_end;
  end
  assign screen_state = state;
endmodule

// File: tb/tb_screen_flow_controller.sv
// tb_screen_flow_controller: scoreboard-driven walk through start, play, over, win and reset paths
module tb_screen_flow_controller;
  logic clk = 1'b0;
  logic resetN = 1'b1;
  logic startOfFrame = 1'b0;
  logic key5IsPressed = 1'b0;
  logic [3:0] life = 4'd3;
  logic [3:0] score = 4'd0;
  logic [7:0] RGB_screen_main = 8'hA5;
  logic [7:0] RGB_screen_start = 8'h11;
  logic [7:0] RGB_screen_end = 8'hEE;
  logic start, game_restart, win;
  logic [7:0] RGB_out;
  logic [1:0] screen_state;
  logic [3:0] high_score;
  int checkCnt = 0;
  int passCnt = 0;
  typedef struct {
    string tag;
    int sel;
    logic [7:0] val;
  } want_t;
  want_t q[$];
  screen_flow_controller dut (
    .clk(clk),
    .resetN(resetN),
    .startOfFrame(startOfFrame),
    .key5IsPressed(key5IsPressed),
    .life(life),
    .score(score),
    .RGB_screen_main(RGB_screen_main),
    .RGB_screen_start(RGB_screen_start),
    .RGB_screen_end(RGB_screen_end),
    .start(start),
    .game_restart(game_restart),
    .RGB_out(RGB_out),
    .screen_state(screen_state),
    .win(win),
    .high_score(high_score)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] observe(input int sel);
    return (sel == 0) ? {6'd0, screen_state} :
           (sel == 1) ? {7'd0, start} :
           (sel == 2) ? {7'd0, game_restart} :
           (sel == 3) ? RGB_out :
           (sel == 4) ? {7'd0, win} : {4'd0, high_score};
  endfunction
  task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic want(input string tag, input int sel, input logic [7:0] val);
    q.push_back('{tag, sel, val});
  endtask
  task automatic tick();
    want_t e;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      checkVal(e.tag, observe(e.sel), e.val);
    end
  endtask
  task automatic frames(input int n);
    startOfFrame = 1'b1;
    repeat (n) tick();
    startOfFrame = 1'b0;
  endtask
  task automatic startGame();
    key5IsPressed = 1'b0;
    tick();
    key5IsPressed = 1'b1;
    want("startState", 0, 8'd1);
    want("startPulse", 1, 8'd1);
    want("startRestart", 2, 8'd0);
    want("startRgb", 3, 8'h11);
    tick();
    key5IsPressed = 1'b0;
    want("startPulseEnd", 1, 8'd0);
    want("playRgb", 3, 8'hA5);
    want("playState", 0, 8'd1);
    tick();
  endtask
  task automatic playTo(input logic [3:0] l, input logic [3:0] s, input logic [1:0] st, input logic [3:0] hs);
    life = l;
    score = s;
    startOfFrame = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want("grace", 0, 8'd1);
      tick();
    end
    want("endState", 0, {6'd0, st});
    want("endNoStart", 1, 8'd0);
    want("endNoRestart", 2, 8'd0);
    want("endWin", 4, {7'd0, st == 2'd3});
    want("endHigh", 5, {4'd0, hs});
    want("endRgbPre", 3, 8'hA5);
    tick();
    startOfFrame = 1'b0;
    want("endRgb", 3, 8'hEE);
    want("endHold", 0, {6'd0, st});
    tick();
  endtask
  task automatic leaveEnd();
    frames(120);
    key5IsPressed = 1'b1;
    want("leaveState", 0, 8'd0);
    want("leavePulse", 2, 8'd1);
    want("leaveNoStart", 1, 8'd0);
    want("leaveWin", 4, 8'd0);
    tick();
    key5IsPressed = 1'b0;
    want("leavePulseEnd", 2, 8'd0);
    want("leaveRgb", 3, 8'h11);
    tick();
  endtask
  initial begin
    resetN = 1'b1;
    tick();
    want("rstState", 0, 8'd0);
    want("rstStart", 1, 8'd0);
    want("rstRestart", 2, 8'd0);
    want("rstRgb", 3, 8'd0);
    want("rstWin", 4, 8'd0);
    want("rstHigh", 5, 8'd0);
    tick();
    resetN = 1'b0;
    startGame();
    playTo(4'd0, 4'd5, 2'd2, 4'd5);
    frames(50);
    key5IsPressed = 1'b1;
    want("press50", 0, 8'd2);
    tick();
    frames(80);
    want("heldPastHold", 0, 8'd2);
    want("heldNoPulse", 2, 8'd0);
    tick();
    key5IsPressed = 1'b0;
    tick();
    key5IsPressed = 1'b1;
    want("press130", 0, 8'd0);
    want("restart130", 2, 8'd1);
    tick();
    key5IsPressed = 1'b0;
    want("restart130End", 2, 8'd0);
    tick();
    startGame();
    playTo(4'd0, 4'd3, 2'd2, 4'd5);
    frames(119);
    key5IsPressed = 1'b1;
    want("press119", 0, 8'd2);
    tick();
    key5IsPressed = 1'b0;
    tick();
    frames(1);
    key5IsPressed = 1'b1;
    want("press120", 0, 8'd0);
    want("restart120", 2, 8'd1);
    tick();
    key5IsPressed = 1'b0;
    tick();
    startGame();
    playTo(4'd0, 4'd9, 2'd2, 4'd9);
    leaveEnd();
    startGame();
    life = 4'd1;
    score = 4'd8;
    frames(10);
    want("score8", 0, 8'd1);
    tick();
    score = 4'd12;
    want("winState", 0, 8'd3);
    want("winFlag", 4, 8'd1);
    want("winHigh", 5, 8'd12);
    tick();
    leaveEnd();
    startGame();
    key5IsPressed = 1'b1;
    frames(3);
    resetN = 1'b1;
    want("midRstState", 0, 8'd0);
    want("midRstStart", 1, 8'd0);
    want("midRstRestart", 2, 8'd0);
    want("midRstRgb", 3, 8'd0);
    want("midRstHigh", 5, 8'd0);
    tick();
    resetN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      want("heldAfterRst", 0, 8'd0);
      want("heldNoStart", 1, 8'd0);
      tick();
    end
    startGame();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
